k12a_mem_ctrl: RTL and testbench
================================

Name: k12a_mem_ctrl

Overview:
Memory-side endpoint of the k12a shared address bus and data bus. It captures addresses driven onto addr_bus by bus masters such as the program counter, and can drive its own memory address register back onto addr_bus. It runs multi-cycle read/write accesses to external asynchronous SRAM through a fixed strobe state machine. A memory data register is exchanged with the CPU over data_bus.

Parameters:
WAIT_CYCLES, 2, number of cycles the SRAM strobe (oe_n or we_n) is held low; legal range 1..15.

Ports:
cpu_clock  input  1  CPU clock; all state updates on rising edge
reset_n  input  1  asynchronous active-low reset
addr_bus  inout  16  shared address bus
mar_store  input  1  latch addr_bus into MAR at the clock edge
mar_load  input  1  drive MAR onto addr_bus (combinational)
data_bus  inout  8  shared CPU data bus
mdr_store  input  1  latch data_bus into MDR at the clock edge
mdr_load  input  1  drive MDR onto data_bus (combinational)
mem_read_req  input  1  start SRAM read at MAR
mem_write_req  input  1  start SRAM write of MDR to MAR
mem_ready  output  1  high when idle and accepting requests
mem_done  output  1  one-cycle completion pulse
ext_addr  output  16  SRAM address, always equal to MAR
ext_data  inout  8  SRAM data
ext_ce_n  output  1  SRAM chip enable, active low
ext_oe_n  output  1  SRAM output enable, active low
ext_we_n  output  1  SRAM write enable, active low

Behaviour:
- Reset (async, immediate):
  - MAR=0000h, MDR=00h, state=IDLE.
  - ext_ce_n=ext_oe_n=ext_we_n=1, mem_ready=1, mem_done=0.
  - addr_bus, data_bus and ext_data high-Z.
- Bus drive:
  - addr_bus = mar_load ? MAR : Z.
  - data_bus = mdr_load ? MDR : Z.
  - ext_data = MDR only in write SETUP/STROBE/HOLD; Z otherwise.
- MAR/MDR loads:
  - Stores are honoured only in IDLE; ignored while busy, so ext_addr and write data stay stable.
  - mar_load together with mar_store is a no-op (MAR reloads itself).
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE. All outputs are registered (glitch-free strobes).
- IDLE:
  - mem_ready=1, all strobes high.
  - mem_read_req or mem_write_req at an edge enters SETUP. The operation type is latched.
  - If both requests are high, read wins and the write request is dropped.
  - Requests in any non-IDLE state are ignored, not queued.
- SETUP (1 cycle): ext_ce_n=0, oe_n/we_n=1. Wait counter loads WAIT_CYCLES-1.
- STROBE (WAIT_CYCLES cycles):
  - ext_ce_n=0. ext_oe_n=0 for a read, ext_we_n=0 for a write.
  - Counter decrements each cycle; leave when the counter is 0.
  - Read: on the edge leaving STROBE, MDR <= ext_data.
- HOLD (1 cycle):
  - ext_ce_n=0, oe_n/we_n=1, mem_done=1.
  - Read data is already visible in MDR during HOLD.
- Timing:
  - mem_ready=0 from SETUP through HOLD.
  - Request-to-done latency = WAIT_CYCLES+2 cycles after the sampling edge.
  - A new request may be sampled in the first IDLE cycle after HOLD (back-to-back throughput WAIT_CYCLES+3).
- Reset mid-access: strobes deassert asynchronously, the access is abandoned, and no mem_done is produced.
- MAR does not auto-increment; wrap-around is not applicable.

Test Plan:
- Reset with reset_n low mid-STROBE of a write -> ext_we_n=1 and ext_ce_n=1 immediately, mem_ready=1, MAR=0000h, MDR=00h, mem_done never pulses.
- mar_store with addr_bus=1234h, then mar_load -> addr_bus reads 1234h and ext_addr=1234h. Also check addr_bus is Z when mar_load=0.
- Write (WAIT_CYCLES=2): MAR=00A0h, MDR=5Ah, mem_write_req -> SETUP 1 cycle, then ext_we_n low exactly 2 cycles with ext_data=5Ah throughout. mem_done pulses in cycle 4. SRAM model holds 5Ah at 00A0h.
- Read from 00A0h -> ext_oe_n low 2 cycles, MDR=5Ah in the mem_done cycle. mdr_load then puts 5Ah on data_bus.
- While busy: mar_store=FFFFh, mdr_store=11h and mem_read_req pulses -> MAR, MDR and ext_addr unchanged, no extra access.
- Simultaneous read+write requests with WAIT_CYCLES=1 -> read performed only, ext_we_n stays high, latency 3 cycles. A back-to-back request sampled the cycle after HOLD starts immediately.

Source files
------------

// File: rtl/k12a_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : k12a_mem_ctrl
//  Brief    : k12a memory-side bus endpoint. Holds the MAR/MDR pair and runs
//             fixed-timing read/write strobe sequences against async SRAM.
//  Revision : 1.0  - initial release
// ============================================================================
module k12a_mem_ctrl #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        cpu_clock,
    input  logic        reset_n,
    inout  wire  [15:0] addr_bus,
    input  logic        mar_store,
    input  logic        mar_load,
    inout  wire  [7:0]  data_bus,
    input  logic        mdr_store,
    input  logic        mdr_load,
    input  logic        mem_read_req,
    input  logic        mem_write_req,
    output logic        mem_ready,
    output logic        mem_done,
    output logic [15:0] ext_addr,
    inout  wire  [7:0]  ext_data,
    output logic        ext_ce_n,
    output logic        ext_oe_n,
    output logic        ext_we_n
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_is_read;
    logic        w_is_read_nxt;
    logic [3:0]  r_wait;
    logic [3:0]  w_wait_nxt;
    logic [15:0] r_mar;
    logic [15:0] w_mar_nxt;
    logic [7:0]  r_mdr;
    logic [7:0]  w_mdr_nxt;

    logic        r_ce_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_ready;
    logic        r_done;
    logic        w_ce_n_nxt;
    logic        w_oe_n_nxt;
    logic        w_we_n_nxt;
    logic        w_ready_nxt;
    logic        w_done_nxt;
    logic        w_ext_drive;

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_is_read <= 1'b0;
            r_wait    <= 4'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_is_read <= w_is_read_nxt;
            r_wait    <= w_wait_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_is_read_nxt = r_is_read;
        w_wait_nxt    = r_wait;
        w_mar_nxt     = r_mar;
        w_mdr_nxt     = r_mdr;

        case (r_state)
            S_IDLE: begin
                // A store while the register is also driving the bus would just reload itself
                if (mar_store && !mar_load) begin
                    w_mar_nxt = addr_bus;
                end
                if (mdr_store && !mdr_load) begin
                    w_mdr_nxt = data_bus;
                end
                if (mem_read_req || mem_write_req) begin
                    w_state_nxt   = S_SETUP;
                    w_is_read_nxt = mem_read_req;
                end
            end
            S_SETUP: begin
                w_state_nxt = S_STROBE;
                w_wait_nxt  = c_WAIT_LOAD;
            end
            S_STROBE: begin
                if (r_wait == 4'd0) begin
                    w_state_nxt = S_HOLD;
                    // oe_n is still low at this edge, so the SRAM is driving ext_data
                    if (r_is_read) begin
                        w_mdr_nxt = ext_data;
                    end
                end else begin
                    w_wait_nxt = r_wait - 4'd1;
                end
            end
            S_HOLD: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they leave a flop cleanly
        w_ce_n_nxt  = (w_state_nxt == S_IDLE);
        w_oe_n_nxt  = !((w_state_nxt == S_STROBE) && w_is_read_nxt);
        w_we_n_nxt  = !((w_state_nxt == S_STROBE) && !w_is_read_nxt);
        w_ready_nxt = (w_state_nxt == S_IDLE);
        w_done_nxt  = (w_state_nxt == S_HOLD);
    end

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mar   <= 16'h0000;
            r_mdr   <= 8'h00;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_mar   <= w_mar_nxt;
            r_mdr   <= w_mdr_nxt;
            r_ce_n  <= w_ce_n_nxt;
            r_oe_n  <= w_oe_n_nxt;
            r_we_n  <= w_we_n_nxt;
            r_ready <= w_ready_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign w_ext_drive = (r_state != S_IDLE) && !r_is_read;

    assign addr_bus  = mar_load    ? r_mar : 16'hzzzz;
    assign data_bus  = mdr_load    ? r_mdr : 8'hzz;
    assign ext_data  = w_ext_drive ? r_mdr : 8'hzz;

    assign ext_addr  = r_mar;
    assign ext_ce_n  = r_ce_n;
    assign ext_oe_n  = r_oe_n;
    assign ext_we_n  = r_we_n;
    assign mem_ready = r_ready;
    assign mem_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_k12a_mem_ctrl.sv
`default_nettype none
// Bench for k12a_mem_ctrl: async SRAM model, queue scoreboard fed by the stimulus,
// monitor checking each completed access against a reference memory.
module tb_k12a_mem_ctrl;

    localparam int WAIT = 2;
    localparam int LAT  = WAIT + 2;

    logic        cpu_clock     = 1'b0;
    logic        reset_n       = 1'b0;
    logic        mar_store     = 1'b0;
    logic        mar_load      = 1'b0;
    logic        mdr_store     = 1'b0;
    logic        mdr_load      = 1'b0;
    logic        mem_read_req  = 1'b0;
    logic        mem_write_req = 1'b0;
    logic        mem_ready;
    logic        mem_done;
    logic [15:0] ext_addr;
    logic        ext_ce_n;
    logic        ext_oe_n;
    logic        ext_we_n;
    wire  [15:0] addr_bus;
    wire  [7:0]  data_bus;
    wire  [7:0]  ext_data;

    logic        tb_addr_en = 1'b0;
    logic [15:0] tb_addr    = 16'h0000;
    logic        tb_data_en = 1'b0;
    logic [7:0]  tb_data    = 8'h00;

    assign addr_bus = tb_addr_en ? tb_addr : 16'hzzzz;
    assign data_bus = tb_data_en ? tb_data : 8'hzz;

    k12a_mem_ctrl #(.WAIT_CYCLES(WAIT)) dut (
        .cpu_clock     (cpu_clock),
        .reset_n       (reset_n),
        .addr_bus      (addr_bus),
        .mar_store     (mar_store),
        .mar_load      (mar_load),
        .data_bus      (data_bus),
        .mdr_store     (mdr_store),
        .mdr_load      (mdr_load),
        .mem_read_req  (mem_read_req),
        .mem_write_req (mem_write_req),
        .mem_ready     (mem_ready),
        .mem_done      (mem_done),
        .ext_addr      (ext_addr),
        .ext_data      (ext_data),
        .ext_ce_n      (ext_ce_n),
        .ext_oe_n      (ext_oe_n),
        .ext_we_n      (ext_we_n)
    );

    always #5 cpu_clock = ~cpu_clock;

    int cyc    = 0;
    int tests  = 0;
    int failed = 0;
    always @(posedge cpu_clock) cyc++;

    // Async SRAM: unwritten cells power up as addr[7:0]^C3
    logic [7:0] sram [logic [15:0]];
    logic [7:0] sram_q;
    always @(negedge ext_oe_n)
        sram_q = sram.exists(ext_addr) ? sram[ext_addr] : (ext_addr[7:0] ^ 8'hC3);
    assign ext_data = (!ext_ce_n && !ext_oe_n) ? sram_q : 8'hzz;
    always @(posedge ext_we_n)
        if (!ext_ce_n && reset_n) sram[ext_addr] = ext_data;

    // Reference model
    logic [7:0]  ref_mem [logic [15:0]];
    logic [15:0] mar_m = 16'h0000;
    logic [7:0]  mdr_m = 8'h00;

    function automatic logic [7:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a[7:0] ^ 8'hC3;
    endfunction

    typedef struct {
        bit          is_read;
        logic [15:0] addr;
        logic [7:0]  data;
        int          issue_cyc;
    } exp_t;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    int   we_cnt    = 0;
    int   oe_cnt    = 0;
    bit   wdata_bad = 1'b0;
    exp_t mon_e;
    always @(negedge cpu_clock) begin
        if (!reset_n) begin
            we_cnt = 0; oe_cnt = 0; wdata_bad = 1'b0;
        end else begin
            if (!ext_we_n) begin
                we_cnt++;
                if (exp_q.size() != 0 && ext_data !== exp_q[0].data) wdata_bad = 1'b1;
            end
            if (!ext_oe_n) oe_cnt++;
            if (mem_done) begin
                if (exp_q.size() == 0) begin
                    check("spurious_done", 32'(mem_done), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_latency", 32'(cyc - mon_e.issue_cyc), 32'(LAT));
                    check("done_addr", 32'(ext_addr), 32'(mon_e.addr));
                    check("done_mdr", 32'(data_bus), 32'(mon_e.data));
                    check("done_ready", 32'(mem_ready), 32'd0);
                    if (mon_e.is_read) begin
                        check("oe_cycles", 32'(oe_cnt), 32'(WAIT));
                        check("we_during_read", 32'(we_cnt), 32'd0);
                    end else begin
                        check("we_cycles", 32'(we_cnt), 32'(WAIT));
                        check("oe_during_write", 32'(oe_cnt), 32'd0);
                        check("we_data_stable", 32'(wdata_bad), 32'd0);
                    end
                end
                we_cnt = 0; oe_cnt = 0; wdata_bad = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge cpu_clock);
        #2;
    endtask

    task automatic set_mar(input logic [15:0] a);
        tb_addr = a; tb_addr_en = 1'b1; mar_store = 1'b1;
        step();
        mar_store = 1'b0; tb_addr_en = 1'b0;
        mar_m = a;
    endtask

    task automatic set_mdr(input logic [7:0] d);
        tb_data = d; tb_data_en = 1'b1; mdr_store = 1'b1;
        step();
        mdr_store = 1'b0; tb_data_en = 1'b0;
        mdr_m = d;
    endtask

    task automatic start(input bit rd, input bit wr);
        exp_t e;
        e.is_read   = rd;
        e.addr      = mar_m;
        e.issue_cyc = cyc;
        if (rd) begin
            e.data = ref_read(mar_m);
        end else begin
            e.data = mdr_m;
            ref_mem[mar_m] = mdr_m;
        end
        mdr_m = e.data;
        exp_q.push_back(e);
        mdr_load = 1'b1; mem_read_req = rd; mem_write_req = wr;
        step();
        mem_read_req = 1'b0; mem_write_req = 1'b0;
        check("req_accepted", 32'(mem_ready), 32'd0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!mem_ready && n < 40) begin
            step();
            n++;
        end
        if (!mem_ready) check("idle_timeout", 32'(mem_ready), 32'd1);
        mdr_load = 1'b0;
    endtask

    task automatic op(input bit rd, input bit wr);
        start(rd, wr);
        wait_idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        mdr_load = 1'b1;
        repeat (3) step();
        check("rst_ce_n", 32'(ext_ce_n), 32'd1);
        check("rst_oe_n", 32'(ext_oe_n), 32'd1);
        check("rst_we_n", 32'(ext_we_n), 32'd1);
        check("rst_ready", 32'(mem_ready), 32'd1);
        check("rst_done", 32'(mem_done), 32'd0);
        check("rst_mar", 32'(ext_addr), 32'h0000);
        check("rst_mdr", 32'(data_bus), 32'h00);
        mdr_load = 1'b0;
        reset_n  = 1'b1;
        step();

        // MAR store / load / bus release
        set_mar(16'h1234);
        check("mar_ext_addr", 32'(ext_addr), 32'h1234);
        mar_load = 1'b1; #1;
        check("mar_on_bus", 32'(addr_bus), 32'h1234);
        mar_load = 1'b0; tb_addr = 16'hEDCB; tb_addr_en = 1'b1; #1;
        check("addr_bus_released", 32'(addr_bus), 32'hEDCB);
        tb_addr_en = 1'b0;
        mar_load = 1'b1; mar_store = 1'b1;
        step();
        mar_load = 1'b0; mar_store = 1'b0;
        check("mar_load_store_noop", 32'(ext_addr), 32'h1234);

        // Directed write then read-back
        set_mar(16'h00A0);
        set_mdr(8'h5A);
        op(1'b0, 1'b1);
        check("sram_00a0", 32'(sram.exists(16'h00A0) ? sram[16'h00A0] : 8'h00), 32'h5A);
        set_mdr(8'h00);
        op(1'b1, 1'b0);
        mdr_load = 1'b1; #1;
        check("mdr_on_bus", 32'(data_bus), 32'h5A);
        mdr_load = 1'b0;

        // Stores and a read request while busy must be ignored
        set_mar(16'h0300);
        set_mdr(8'hC6);
        start(1'b0, 1'b1);
        mdr_load = 1'b0;
        tb_addr = 16'hFFFF; tb_addr_en = 1'b1; mar_store = 1'b1;
        tb_data = 8'h11; tb_data_en = 1'b1; mdr_store = 1'b1; mem_read_req = 1'b1;
        for (int i = 0; i < WAIT; i++) step();
        mar_store = 1'b0; mdr_store = 1'b0; mem_read_req = 1'b0;
        tb_addr_en = 1'b0; tb_data_en = 1'b0; mdr_load = 1'b1;
        wait_idle();
        check("busy_mar_kept", 32'(ext_addr), 32'h0300);
        repeat (LAT + 2) step();
        check("busy_no_extra_access", 32'(mem_ready), 32'd1);

        // Read wins over simultaneous write; back-to-back read from first idle cycle
        set_mar(16'h0042);
        set_mdr(8'h99);
        op(1'b1, 1'b1);
        op(1'b1, 1'b0);
        check("read_wins_sram", 32'(sram.exists(16'h0042)), 32'd0);

        // Randomised traffic over a small window so reads hit earlier writes
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 3) != 0) set_mar(16'h0400 + 16'($urandom_range(0, 7)));
            if ($urandom_range(0, 1) == 1) begin
                set_mdr(8'($urandom));
                op(1'b0, 1'b1);
            end else begin
                op(1'b1, $urandom_range(0, 3) == 0);
            end
        end

        // Reset in the middle of a write strobe
        set_mar(16'h0555);
        set_mdr(8'hE7);
        start(1'b0, 1'b1);
        begin
            int n = 0;
            while (ext_we_n && n < 10) begin
                step();
                n++;
            end
        end
        check("we_low_seen", 32'(ext_we_n), 32'd0);
        #1 reset_n = 1'b0;
        #1;
        check("arst_we_n", 32'(ext_we_n), 32'd1);
        check("arst_ce_n", 32'(ext_ce_n), 32'd1);
        check("arst_ready", 32'(mem_ready), 32'd1);
        check("arst_done", 32'(mem_done), 32'd0);
        check("arst_mar", 32'(ext_addr), 32'h0000);
        check("arst_mdr", 32'(data_bus), 32'h00);
        exp_q.delete();
        ref_mem.delete(16'h0555);
        mar_m = 16'h0000;
        mdr_m = 8'h00;
        step();
        step();
        reset_n  = 1'b1;
        mdr_load = 1'b0;
        repeat (LAT + 2) step();
        check("arst_stays_idle", 32'(mem_ready), 32'd1);

        // Controller still works after the abort
        set_mar(16'h00A0);
        op(1'b1, 1'b0);

        repeat (4) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
